// File: rtl/lorenz_pkg.sv
// Shared widths, state codes and saturation helper
// for the Lorenz-attractor stepper.
package lorenz_pkg;

  localparam int WIDTH_DEF = 27;
  localparam int FRAC_DEF  = 20;
  localparam int CNT_W_DEF = 16;
  localparam int MAXW      = 64;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  typedef logic [2:0] phase_t;

  localparam logic signed [WIDTH_DEF-1:0] SAT_MAX =
    {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic signed [WIDTH_DEF-1:0] SAT_MIN =
    {1'b1, {(WIDTH_DEF-1){1'b0}}};

  // Clamp v to a signed w-bit range; callers size-cast the result to w.
  function automatic logic signed [MAXW-1:0] saturate(
    input  logic signed [MAXW-1:0] v,
    input  int unsigned            w,
    output logic                   hit
  );
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    logic signed [MAXW-1:0] r;
    hi  = (MAXW'(1) <<< (w - 1)) - MAXW'(1);
    lo  = ~hi;
    hit = (v > hi) || (v < lo);
    r   = v;
    if (v > hi) r = hi;
    if (v < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/lorenz_stepper_fix_mult_sat.sv
// Signed fixed-point multiply: full product, shift by FRAC,
// saturate back to WIDTH and flag the clamp.
module fix_mult_sat
  import lorenz_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             sat
);

  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] shifted;

  always_comb begin
    full    = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
    shifted = full >>> FRAC;
    p       = WIDTH'(saturate(MAXW'(shifted), WIDTH, sat));
  end

endmodule

// File: rtl/lorenz_stepper.sv
// Forward-Euler Lorenz integrator, eight phases per step
// sharing one saturating multiplier.
module lorenz_stepper
  import lorenz_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] init_x,
  input  logic [WIDTH-1:0] init_y,
  input  logic [WIDTH-1:0] init_z,
  input  logic [WIDTH-1:0] sigma,
  input  logic [WIDTH-1:0] beta,
  input  logic [WIDTH-1:0] rho,
  input  logic [WIDTH-1:0] dt,
  input  logic [CNT_W-1:0] num_steps,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] step_count
);

  state_t           state;
  phase_t           phase;
  logic [WIDTH-1:0] sig_r, beta_r, rho_r, dt_r;
  logic [CNT_W-1:0] nsteps_r;
  logic [WIDTH-1:0] p0, p1, p2, p3, p4, p5, p6;
  logic             stop_pend;

  logic [WIDTH-1:0]  as_a, as_b, as_res;
  logic signed [WIDTH:0] as_sum;
  logic              as_hit;
  logic [WIDTH-1:0]  mul_a, mul_b, mul_p;
  logic              mul_hit;

  logic signed [WIDTH:0] sx, sy, sz;
  logic [WIDTH-1:0]  nx, ny, nz;
  logic              hx, hy, hz;
  logic [CNT_W-1:0]  next_cnt;
  logic              last_step;
  logic              ovf_evt;

  always_comb begin
    as_a = '0;
    as_b = '0;
    case (phase)
      3'd0: begin as_a = y;     as_b = x;  end
      3'd1: begin as_a = rho_r; as_b = z;  end
      3'd5: begin as_a = p1;    as_b = y;  end
      3'd6: begin as_a = p2;    as_b = p3; end
      default: ;
    endcase
  end

  always_comb begin
    as_sum = (WIDTH+1)'($signed(as_a))
           - (WIDTH+1)'($signed(as_b));
    as_res = WIDTH'(saturate(MAXW'(as_sum), WIDTH, as_hit));
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (phase)
      3'd0: begin mul_a = sig_r;  mul_b = as_res; end
      3'd1: begin mul_a = x;      mul_b = as_res; end
      3'd2: begin mul_a = x;      mul_b = y;      end
      3'd3: begin mul_a = beta_r; mul_b = z;      end
      3'd4: begin mul_a = dt_r;   mul_b = p0;     end
      3'd5: begin mul_a = dt_r;   mul_b = as_res; end
      3'd6: begin mul_a = dt_r;   mul_b = as_res; end
      default: ;
    endcase
  end

  fix_mult_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mult (
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .sat (mul_hit)
  );

  always_comb begin
    sx = (WIDTH+1)'($signed(x)) + (WIDTH+1)'($signed(p4));
    sy = (WIDTH+1)'($signed(y)) + (WIDTH+1)'($signed(p5));
    sz = (WIDTH+1)'($signed(z)) + (WIDTH+1)'($signed(p6));
    nx = WIDTH'(saturate(MAXW'(sx), WIDTH, hx));
    ny = WIDTH'(saturate(MAXW'(sy), WIDTH, hy));
    nz = WIDTH'(saturate(MAXW'(sz), WIDTH, hz));
    next_cnt  = step_count + CNT_W'(1);
    last_step = ((nsteps_r != '0) && (next_cnt == nsteps_r))
              || stop_pend || stop;
    ovf_evt   = (phase == 3'd7) ? (hx | hy | hz)
                                : (as_hit | mul_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      phase        <= '0;
      sig_r        <= '0;
      beta_r       <= '0;
      rho_r        <= '0;
      dt_r         <= '0;
      nsteps_r     <= '0;
      p0           <= '0;
      p1           <= '0;
      p2           <= '0;
      p3           <= '0;
      p4           <= '0;
      p5           <= '0;
      p6           <= '0;
      stop_pend    <= 1'b0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      step_count   <= '0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      // busy trails state so it drops one cycle after done
      busy         <= (state == ST_RUN);
      if (state == ST_IDLE) begin
        if (start && !busy) begin
          sig_r      <= sigma;
          beta_r     <= beta;
          rho_r      <= rho;
          dt_r       <= dt;
          nsteps_r   <= num_steps;
          x          <= init_x;
          y          <= init_y;
          z          <= init_z;
          step_count <= '0;
          overflow   <= 1'b0;
          phase      <= '0;
          stop_pend  <= stop;
          busy       <= 1'b1;
          state      <= ST_RUN;
        end
      end else begin
        phase <= phase + 3'd1;
        if (stop) stop_pend <= 1'b1;
        if (ovf_evt) overflow <= 1'b1;
        case (phase)
          3'd0: p0 <= mul_p;
          3'd1: p1 <= mul_p;
          3'd2: p2 <= mul_p;
          3'd3: p3 <= mul_p;
          3'd4: p4 <= mul_p;
          3'd5: p5 <= mul_p;
          3'd6: p6 <= mul_p;
          default: begin
            x            <= nx;
            y            <= ny;
            z            <= nz;
            step_count   <= next_cnt;
            sample_valid <= 1'b1;
            stop_pend    <= 1'b0;
            if (last_step) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lorenz_stepper.sv
// Randomised and directed checks of lorenz_stepper against
// a plain-arithmetic Euler model.
module tb_lorenz_stepper;

  localparam int W = 27;
  localparam int F = 20;
  localparam int C = 16;
  localparam longint ONE  = longint'(1) <<< F;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [W-1:0] init_x = '0, init_y = '0, init_z = '0;
  logic [W-1:0] sigma = '0, beta = '0, rho = '0, dt = '0;
  logic [C-1:0] num_steps = '0;
  logic [W-1:0] x, y, z;
  logic sample_valid, busy, done, overflow;
  logic [C-1:0] step_count;

  logic start2 = 1'b0;
  logic stop2 = 1'b0;
  logic [3:0] ns2 = '0;
  logic [W-1:0] x2, y2, z2;
  logic sv2, busy2, done2, ovf2;
  logic [3:0] sc2;

  int n_cmp = 0;
  int n_bad = 0;

  longint mx, my, mz;
  bit     m_ovf;

  always #5 clk = ~clk;

  lorenz_stepper #(.WIDTH(W), .FRAC(F), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .init_x(init_x), .init_y(init_y), .init_z(init_z),
    .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .num_steps(num_steps),
    .x(x), .y(y), .z(z),
    .sample_valid(sample_valid), .busy(busy), .done(done),
    .overflow(overflow), .step_count(step_count)
  );

  lorenz_stepper #(.WIDTH(W), .FRAC(F), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2),
    .init_x(init_x), .init_y(init_y), .init_z(init_z),
    .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .num_steps(ns2),
    .x(x2), .y(y2), .z(z2),
    .sample_valid(sv2), .busy(busy2), .done(done2),
    .overflow(ovf2), .step_count(sc2)
  );

  task automatic expect_eq(input string tag, input longint got,
                           input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sgn(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
    if (v < MINV) begin m_ovf = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat((a * b) >>> F);
  endfunction

  task automatic model_step(input longint s, input longint b,
                            input longint r, input longint d);
    longint dx, dy, dz;
    dx = fmul(d, fmul(s, sat(my - mx)));
    dy = fmul(d, sat(fmul(mx, sat(r - mz)) - my));
    dz = fmul(d, sat(fmul(mx, my) - fmul(b, mz)));
    mx = sat(mx + dx);
    my = sat(my + dy);
    mz = sat(mz + dz);
  endtask

  task automatic do_run(input string nm,
                        input longint ix, input longint iy,
                        input longint iz, input longint s,
                        input longint b, input longint r,
                        input longint d, input int n,
                        input int stop_at, input bit with_stop);
    int cyc, steps, budget;
    bit fin;
    @(negedge clk);
    init_x = W'(ix); init_y = W'(iy); init_z = W'(iz);
    sigma = W'(s); beta = W'(b); rho = W'(r); dt = W'(d);
    num_steps = C'(n);
    start = 1'b1;
    stop = with_stop;
    @(posedge clk); #1;
    expect_eq({nm, "/x0"}, sgn(x), ix);
    expect_eq({nm, "/busy0"}, longint'(busy), 1);
    expect_eq({nm, "/ovf0"}, longint'(overflow), 0);
    mx = ix; my = iy; mz = iz; m_ovf = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    // scramble coefficient inputs: they must already be latched
    sigma = W'($urandom); beta = W'($urandom);
    rho = W'($urandom); dt = W'($urandom);
    init_x = W'($urandom);
    cyc = 0; steps = 0; fin = 1'b0;
    budget = 8 * ((n != 0) ? n : ((stop_at != 0) ? stop_at : 1)) + 16;
    while (!fin && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      stop = 1'b0;
      if (cyc % 8 == 0) begin
        model_step(s, b, r, d);
        steps++;
        fin = (n != 0 && steps == n) ||
              (stop_at != 0 && steps == stop_at) ||
              (with_stop && steps == 1);
        expect_eq({nm, "/sv"}, longint'(sample_valid), 1);
        expect_eq({nm, "/x"}, sgn(x), mx);
        expect_eq({nm, "/y"}, sgn(y), my);
        expect_eq({nm, "/z"}, sgn(z), mz);
        expect_eq({nm, "/cnt"}, longint'(step_count),
                  longint'(steps % (1 << C)));
        expect_eq({nm, "/ovf"}, longint'(overflow), longint'(m_ovf));
        expect_eq({nm, "/done"}, longint'(done), longint'(fin));
      end else begin
        expect_eq({nm, "/quiet"}, longint'({sample_valid, done}), 0);
      end
      if (stop_at != 0 && cyc == 8 * (stop_at - 1) + 3) begin
        stop = 1'b1;
        start = 1'b1;
      end
    end
    if (!fin) expect_eq({nm, "/timeout"}, 0, 1);
    expect_eq({nm, "/busy_hold"}, longint'(busy), 1);
    @(posedge clk); #1;
    expect_eq({nm, "/busy_end"}, longint'(busy), 0);
    expect_eq({nm, "/done_end"}, longint'(done), 0);
  endtask

  longint c_x, c_y, c_z, c_s, c_b, c_r, c_d;

  initial begin
    c_x = -ONE;
    c_y = 104858;
    c_z = 25 * ONE;
    c_s = 10 * ONE;
    c_b = 2796203;
    c_r = 28 * ONE;
    c_d = ONE >>> 8;

    #12;
    expect_eq("rst/x", longint'(x), 0);
    expect_eq("rst/flags",
              longint'({sample_valid, busy, done, overflow}), 0);
    expect_eq("rst/cnt", longint'(step_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_run("single", c_x, c_y, c_z, c_s, c_b, c_r, c_d, 1, 0, 0);
    expect_eq("single/x_gold", sgn(x), -1003520);

    do_run("multi", c_x, c_y, c_z, c_s, c_b, c_r, c_d, 1000, 0, 0);
    expect_eq("multi/cnt_end", longint'(step_count), 1000);

    do_run("sat", 60 * ONE, -60 * ONE, c_z, c_s, c_b, c_r, c_d,
           2, 0, 0);
    expect_eq("sat/ovf_sticky", longint'(overflow), 1);
    repeat (3) @(posedge clk);
    #1;
    expect_eq("sat/ovf_idle", longint'(overflow), 1);

    do_run("stop", c_x, c_y, c_z, c_s, c_b, c_r, c_d, 0, 5, 0);
    expect_eq("stop/cnt", longint'(step_count), 5);

    do_run("startstop", c_x, c_y, c_z, c_s, c_b, c_r, c_d, 0, 0, 1);
    expect_eq("startstop/cnt", longint'(step_count), 1);

    // asynchronous reset in phase 4 of the first step
    @(negedge clk);
    init_x = W'(c_x); init_y = W'(c_y); init_z = W'(c_z);
    sigma = W'(c_s); beta = W'(c_b); rho = W'(c_r); dt = W'(c_d);
    num_steps = C'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_eq("arst/xyz", longint'({x, y, z}), 0);
    expect_eq("arst/flags",
              longint'({sample_valid, busy, done, overflow}), 0);
    expect_eq("arst/cnt", longint'(step_count), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      expect_eq("arst/no_done", longint'({done, busy}), 0);
    end
    do_run("restart", c_x, c_y, c_z, c_s, c_b, c_r, c_d, 1, 0, 0);
    expect_eq("restart/x_gold", sgn(x), -1003520);

    for (int k = 0; k < 6; k++) begin
      longint rx, ry, rz, rs, rb, rr, rd;
      rx = longint'($urandom_range(0, 40 * ONE)) - 20 * ONE;
      ry = longint'($urandom_range(0, 40 * ONE)) - 20 * ONE;
      rz = longint'($urandom_range(0, 50 * ONE));
      rs = longint'($urandom_range(0, 15 * ONE));
      rb = longint'($urandom_range(0, 4 * ONE));
      rr = longint'($urandom_range(0, 40 * ONE));
      rd = ONE >>> $urandom_range(4, 10);
      do_run("rand", rx, ry, rz, rs, rb, rr, rd,
             int'($urandom_range(1, 12)), 0, 0);
    end

    // step_count wrap on the 4-bit instance
    @(negedge clk);
    init_x = W'(c_x); init_y = W'(c_y); init_z = W'(c_z);
    sigma = W'(c_s); beta = W'(c_b); rho = W'(c_r); dt = W'(c_d);
    ns2 = '0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    mx = c_x; my = c_y; mz = c_z; m_ovf = 1'b0;
    for (int c = 1; c <= 8 * 18; c++) begin
      @(posedge clk); #1;
      stop2 = 1'b0;
      if (c % 8 == 0) begin
        model_step(c_s, c_b, c_r, c_d);
        expect_eq("wrap/cnt", longint'(sc2), longint'((c / 8) % 16));
        expect_eq("wrap/x", sgn(x2), mx);
        expect_eq("wrap/busy", longint'(busy2), 1);
        expect_eq("wrap/done", longint'(done2),
                  longint'(c == 8 * 18));
        if (c == 8 * 17) stop2 = 1'b1;
      end
    end
    @(posedge clk); #1;
    expect_eq("wrap/busy_end", longint'(busy2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
